intra4_mode_sched: RTL

- Controller for the 4x4 intra residual stage. It issues the one-cycle enable to the residual register bank.
- It then steps a mode select over the eight directional residual vectors, one mode per cycle, and accumulates a SAD for each.
- It reports the lowest-cost mode and its SAD to the mode-decision/transform front end.
- An external 8:1 mux, driven by mode_sel, routes the selected 16-pixel residual vector into res.

---
 rtl/intra4_mode_sched_if.sv | 31 +++
 rtl/intra4_mode_sched.sv | 118 +++++++++++
 2 files changed

// File: rtl/intra4_mode_sched_if.sv
// Handshake and data bundle between the 4x4 intra mode scheduler and its
// residual bank / mode-decision front end.
`default_nettype none

interface intra4_mode_sched_if #(
  parameter int NUM_MODES = 8,
  parameter int SAD_W     = 12
);
  logic                 start;
  logic [NUM_MODES-1:0] mode_mask;
  logic [7:0]           res [16];
  logic                 res_en;
  logic [2:0]           mode_sel;
  logic                 busy;
  logic                 done;
  logic [2:0]           best_mode;
  logic [SAD_W-1:0]     best_sad;
  logic                 best_valid;

  modport master (
    output start, mode_mask, res,
    input  res_en, mode_sel, busy, done, best_mode, best_sad, best_valid
  );

  modport slave (
    input  start, mode_mask, res,
    output res_en, mode_sel, busy, done, best_mode, best_sad, best_valid
  );
endinterface

`default_nettype wire

// File: rtl/intra4_mode_sched.sv
// 4x4 intra residual scheduler: pulses the residual bank, scans enabled modes
// and keeps the lowest-SAD mode. Optional macro INTRA4_SAD_EARLY_EXIT_EN.
`default_nettype none

module intra4_mode_sched #(
  parameter int NUM_MODES = 8,
  parameter int SAD_W     = 12
) (
  input  logic                clk,
  input  logic                reset,
  intra4_mode_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_MODES-1:0] mask_q;
  logic [NUM_MODES-1:0] mask_rest;
  logic [2:0]           mode_q;
  logic [2:0]           best_mode_q;
  logic [SAD_W-1:0]     best_sad_q;
  logic                 best_valid_q;
  logic [SAD_W-1:0]     cur_sad;
  logic [7:0]           mag;
  logic                 take_best;
  logic                 early_exit;

  function automatic logic [2:0] lowest_bit(input logic [NUM_MODES-1:0] m);
    lowest_bit = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  // Two's-complement negate in 8 bits maps -128 to 8'h80, which read unsigned is 128.
  always_comb begin
    cur_sad = '0;
    mag     = '0;
    for (int i = 0; i < 16; i++) begin
      mag     = bus.res[i][7] ? (~bus.res[i] + 8'd1) : bus.res[i];
      cur_sad = cur_sad + SAD_W'(mag);
    end
  end

  assign mask_rest = mask_q & ~(NUM_MODES'(1) << mode_q);
  assign take_best = !best_valid_q || (cur_sad < best_sad_q);

`ifdef INTRA4_SAD_EARLY_EXIT_EN
  assign early_exit = (cur_sad == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = (mask_q == '0) ? DONE : SCAN;
      SCAN:    if ((mask_rest == '0) || early_exit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q       <= '0;
      mode_q       <= '0;
      best_mode_q  <= '0;
      best_sad_q   <= '1;
      best_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mask_q       <= bus.mode_mask;
            best_mode_q  <= '0;
            best_sad_q   <= '1;
            best_valid_q <= 1'b0;
          end
        end
        LOAD: mode_q <= lowest_bit(mask_q);
        SCAN: begin
          if (take_best) begin
            best_mode_q  <= mode_q;
            best_sad_q   <= cur_sad;
            best_valid_q <= 1'b1;
          end
          mask_q <= mask_rest;
          mode_q <= lowest_bit(mask_rest);
        end
        default: mode_q <= '0;
      endcase
    end
  end

  assign bus.res_en     = (state == LOAD);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.mode_sel   = (state == SCAN) ? mode_q : 3'd0;
  assign bus.best_mode  = best_mode_q;
  assign bus.best_sad   = best_sad_q;
  assign bus.best_valid = best_valid_q;

endmodule

`default_nettype wire
